// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard unit: MIPS opcodes,
// the in-flight scoreboard entry, the decoded ID instruction, and the
// width helper for the forwarding-select outputs.
package hazard_pkg;

  // MIPS register fields are always 5 bits in the instruction word; the
  // unit compares only the low REG_AW bits of them.
  localparam int REG_FIELD_W = 5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  // One tracked in-flight instruction (EX..WB). we=0 marks a bubble.
  typedef struct packed {
    logic                   we;
    logic [REG_FIELD_W-1:0] dst;
    logic                   is_load;
  } sb_entry_t;

  // What the ID-stage instruction reads and writes.
  typedef struct packed {
    logic                   use_rs;
    logic                   use_rt;
    logic [REG_FIELD_W-1:0] rs;
    logic [REG_FIELD_W-1:0] rt;
    logic                   we;
    logic [REG_FIELD_W-1:0] dst;
    logic                   is_load;
  } dec_t;

  // Select code 0 = register file, k = scoreboard entry k-1.
  function automatic int fwd_sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipeline_hazard_unit_if.sv
// ID-stage side of the hazard unit: the instruction under decode plus the
// freeze/squash controls in, and the stall / forwarding decisions out.
//
// Contract: there is no valid/ready pair here. Every cycle the ID stage
// presents id_ir (all-zero = bubble); the unit answers in the same cycle.
// stall=1 means "this ID instruction is not accepted": the ID stage must
// hold PC and IF/ID and present the same id_ir again next cycle, while EX
// receives a bubble. stall=0 means the instruction is accepted on the next
// clock edge with the operand sources named by fwd_a_sel / fwd_b_sel.
interface pipeline_hazard_unit_if
  import hazard_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
) ();

  localparam int SEL_W = fwd_sel_w(DEPTH);

  logic [31:0]      id_ir;
  logic             hold_ext;
  logic             flush;
  logic             stall;
  logic [SEL_W-1:0] fwd_a_sel;
  logic [SEL_W-1:0] fwd_b_sel;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_ir, hold_ext, flush,
    input  stall, fwd_a_sel, fwd_b_sel, stall_cycles
  );

  modport slave (
    input  id_ir, hold_ext, flush,
    output stall, fwd_a_sel, fwd_b_sel, stall_cycles
  );

endinterface

// File: rtl/hazard_decode.sv
// Combinational decode of a MIPS instruction word into its register
// reads/writes. Writes to $0 and the all-zero bubble write nothing.
module hazard_decode
  import hazard_pkg::*;
(
  input  logic [31:0] ir,
  output dec_t        dec
);

  logic [5:0] op;
  logic       unused_ir_bits;

  assign op             = ir[31:26];
  assign unused_ir_bits = ^ir[10:0];

  // Opcode classes decide which source fields are read and which field is written.
  always_comb begin
    dec    = '0;
    dec.rs = ir[25:21];
    dec.rt = ir[20:16];
    if (ir != 32'b0) begin
      case (op)
        OP_RTYPE: begin
          dec.use_rs = 1'b1;
          dec.use_rt = 1'b1;
          dec.we     = 1'b1;
          dec.dst    = ir[15:11];
        end
        OP_LW: begin
          dec.use_rs  = 1'b1;
          dec.we      = 1'b1;
          dec.dst     = ir[20:16];
          dec.is_load = 1'b1;
        end
        OP_SW, OP_BEQ, OP_BNE: begin
          dec.use_rs = 1'b1;
          dec.use_rt = 1'b1;
        end
        OP_J: begin
          dec.use_rs = 1'b0;
        end
        default: begin
          dec.use_rs = 1'b1;
          dec.we     = 1'b1;
          dec.dst    = ir[20:16];
        end
      endcase
      if (dec.dst == '0) begin
        dec.we = 1'b0;
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard detection and forwarding control beside the ID stage. Keeps a
// shift-register scoreboard of in-flight destinations (entry 0 = EX,
// entry DEPTH-1 = WB), matches the ID sources against it youngest-first,
// and either stalls or names the stage to forward from.
module pipeline_hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int FWD_EN   = 1,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  pipeline_hazard_unit_if.slave bus
);

  localparam int SEL_W = fwd_sel_w(DEPTH);

  dec_t                  id_dec;
  sb_entry_t [DEPTH-1:0] sb;
  sb_entry_t             new_entry;
  logic                  hazard_a;
  logic                  hazard_b;
  logic                  hazard;
  logic [SEL_W-1:0]      sel_a_raw;
  logic [SEL_W-1:0]      sel_b_raw;
  logic [CNT_W-1:0]      cnt;

  hazard_decode u_decode (
    .ir  (bus.id_ir),
    .dec (id_dec)
  );

  // Youngest matching producer wins. A load still inside its first
  // LOAD_LAT entries has no data to forward yet, so it forces a stall.
  function automatic void lookup(
    input  sb_entry_t [DEPTH-1:0] ent,
    input  logic                  use_src,
    input  logic [REG_FIELD_W-1:0] src,
    output logic                  haz,
    output logic [SEL_W-1:0]      sel
  );
    logic hit;
    logic load;
    int   idx;
    hit  = 1'b0;
    load = 1'b0;
    idx  = 0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (use_src && ent[k].we && (ent[k].dst[REG_AW-1:0] == src[REG_AW-1:0])) begin
        hit  = 1'b1;
        load = ent[k].is_load;
        idx  = k;
      end
    end
    haz = 1'b0;
    sel = '0;
    if (hit) begin
      if (FWD_EN == 0) begin
        haz = 1'b1;
      end else if (load && (idx < LOAD_LAT)) begin
        haz = 1'b1;
      end else begin
        sel = SEL_W'(idx + 1);
      end
    end
  endfunction

  // Per-source match against the registered scoreboard.
  always_comb begin
    lookup(sb, id_dec.use_rs, id_dec.rs, hazard_a, sel_a_raw);
    lookup(sb, id_dec.use_rt, id_dec.rt, hazard_b, sel_b_raw);
  end

  assign hazard = hazard_a | hazard_b;

  // Outputs: a flushed instruction never stalls; no forwarding is named
  // for an instruction that is not issuing this cycle.
  assign bus.stall        = bus.hold_ext | (hazard & ~bus.flush);
  assign bus.fwd_a_sel    = (hazard | bus.flush) ? '0 : sel_a_raw;
  assign bus.fwd_b_sel    = (hazard | bus.flush) ? '0 : sel_b_raw;
  assign bus.stall_cycles = cnt;

  // Entry that enters EX: a bubble when stalled or squashed.
  always_comb begin
    new_entry = '0;
    if (!hazard && !bus.flush) begin
      new_entry.we      = id_dec.we;
      new_entry.dst     = id_dec.dst;
      new_entry.is_load = id_dec.is_load;
    end
  end

  // Scoreboard advances one stage per cycle unless the pipeline is frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb <= '0;
    end else if (!bus.hold_ext) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        sb[i] <= sb[i-1];
      end
      sb[0] <= new_entry;
    end
  end

  // Saturating count of cycles lost to genuine hazards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (hazard && !bus.flush && !bus.hold_ext && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed bench for pipeline_hazard_unit. Three instances share one set of
// driven inputs: forwarding (CNT_W=16), no-forwarding, and a 4-bit counter
// instance for saturation. Each driven cycle pushes the expected outputs of
// one chosen instance; a negedge monitor pops and compares.
module tb_pipeline_hazard_unit;

  localparam int DUT_FWD = 0;
  localparam int DUT_NOF = 1;
  localparam int DUT_SAT = 2;

  typedef struct {
    int          which;
    logic        stall;
    logic [1:0]  a;
    logic [1:0]  b;
    logic [15:0] cnt;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] ir;
  logic        hold;
  logic        fl;

  exp_t exp_q[$];
  int   checks;
  int   errors;

  pipeline_hazard_unit_if #(.DEPTH(3), .CNT_W(16)) bus_fwd ();
  pipeline_hazard_unit_if #(.DEPTH(3), .CNT_W(16)) bus_nof ();
  pipeline_hazard_unit_if #(.DEPTH(3), .CNT_W(4))  bus_sat ();

  assign bus_fwd.id_ir    = ir;
  assign bus_fwd.hold_ext = hold;
  assign bus_fwd.flush    = fl;
  assign bus_nof.id_ir    = ir;
  assign bus_nof.hold_ext = hold;
  assign bus_nof.flush    = fl;
  assign bus_sat.id_ir    = ir;
  assign bus_sat.hold_ext = hold;
  assign bus_sat.flush    = fl;

  pipeline_hazard_unit #(
    .REG_AW(5), .DEPTH(3), .FWD_EN(1), .LOAD_LAT(1), .CNT_W(16)
  ) u_fwd (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_fwd)
  );

  pipeline_hazard_unit #(
    .REG_AW(5), .DEPTH(3), .FWD_EN(0), .LOAD_LAT(1), .CNT_W(16)
  ) u_nof (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_nof)
  );

  pipeline_hazard_unit #(
    .REG_AW(5), .DEPTH(3), .FWD_EN(1), .LOAD_LAT(1), .CNT_W(4)
  ) u_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_sat)
  );

  // Clock and initial reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst_n = 1'b0;
    ir    = 32'b0;
    hold  = 1'b0;
    fl    = 1'b0;
  end

  // Instruction builders
  function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {6'b000000, rs, rt, rd, 5'b00000, funct};
  endfunction

  function automatic logic [31:0] lw_ins(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [15:0] imm);
    return {6'b100011, rs, rt, imm};
  endfunction

  // Driver: apply one cycle of inputs just after the edge, queue expectation
  task automatic cyc(input logic r, input logic [31:0] ir_v, input logic h, input logic f,
                     input int which, input logic es, input logic [1:0] ea,
                     input logic [1:0] eb, input logic [15:0] ec, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r;
    ir    = ir_v;
    hold  = h;
    fl    = f;
    e.which = which;
    e.stall = es;
    e.a     = ea;
    e.b     = eb;
    e.cnt   = ec;
    e.name  = nm;
    exp_q.push_back(e);
  endtask

  task automatic nops(input int which, input logic [15:0] ec, input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 32'b0, 1'b0, 1'b0, which, 1'b0, 2'd0, 2'd0, ec, "nop");
    end
  endtask

  // Scoreboard monitor: compare the selected instance mid-cycle
  always @(negedge clk) begin
    exp_t        e;
    logic        act_stall;
    logic [1:0]  act_a;
    logic [1:0]  act_b;
    logic [15:0] act_cnt;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.which)
        DUT_FWD: begin
          act_stall = bus_fwd.stall;
          act_a     = bus_fwd.fwd_a_sel;
          act_b     = bus_fwd.fwd_b_sel;
          act_cnt   = bus_fwd.stall_cycles;
        end
        DUT_NOF: begin
          act_stall = bus_nof.stall;
          act_a     = bus_nof.fwd_a_sel;
          act_b     = bus_nof.fwd_b_sel;
          act_cnt   = bus_nof.stall_cycles;
        end
        default: begin
          act_stall = bus_sat.stall;
          act_a     = bus_sat.fwd_a_sel;
          act_b     = bus_sat.fwd_b_sel;
          act_cnt   = {12'b0, bus_sat.stall_cycles};
        end
      endcase
      checks++;
      if (act_stall !== e.stall || act_a !== e.a || act_b !== e.b || act_cnt !== e.cnt) begin
        errors++;
        $display("FAIL %s (dut %0d): got stall=%0b a=%0d b=%0d cnt=%0d, expected stall=%0b a=%0d b=%0d cnt=%0d",
                 e.name, e.which, act_stall, act_a, act_b, act_cnt,
                 e.stall, e.a, e.b, e.cnt);
      end
    end
  end

  // Directed stimulus
  initial begin
    logic [31:0] add_3_1_2;
    logic [31:0] sub_4_3_5;
    logic [31:0] add_7_3_4;
    logic [31:0] lw_3;
    logic [31:0] add_4_3_3;
    logic [31:0] or_6_3_0;
    logic [31:0] or_6_4_0;
    logic [15:0] c;
    int          wait_cycles;

    checks = 0;
    errors = 0;

    add_3_1_2 = r_ins(5'd1, 5'd2, 5'd3, 6'h20);
    sub_4_3_5 = r_ins(5'd3, 5'd5, 5'd4, 6'h22);
    add_7_3_4 = r_ins(5'd3, 5'd4, 5'd7, 6'h20);
    lw_3      = lw_ins(5'd1, 5'd3, 16'h0000);
    add_4_3_3 = r_ins(5'd3, 5'd3, 5'd4, 6'h20);
    or_6_3_0  = r_ins(5'd3, 5'd0, 5'd6, 6'h25);
    or_6_4_0  = r_ins(5'd4, 5'd0, 5'd6, 6'h25);

    // Reset state
    cyc(1'b0, 32'b0, 1'b0, 1'b0, DUT_FWD, 1'b0, 2'd0, 2'd0, 16'd0, "reset_fwd");
    cyc(1'b0, 32'b0, 1'b0, 1'b0, DUT_NOF, 1'b0, 2'd0, 2'd0, 16'd0, "reset_nof");

    // ALU back-to-back forwarding, then EX->sel1, WB->sel3, MEM->sel2
    cyc(1'b1, add_3_1_2, 1'b0, 1'b0, DUT_FWD, 1'b0, 2'd0, 2'd0, 16'd0, "add_issue");
    cyc(1'b1, sub_4_3_5, 1'b0, 1'b0, DUT_FWD, 1'b0, 2'd1, 2'd0, 16'd0, "sub_fwd_ex");
    cyc(1'b1, 32'b0,     1'b0, 1'b0, DUT_FWD, 1'b0, 2'd0, 2'd0, 16'd0, "gap_nop");
    cyc(1'b1, add_7_3_4, 1'b0, 1'b0, DUT_FWD, 1'b0, 2'd3, 2'd2, 16'd0, "fwd_wb_mem");
    nops(DUT_FWD, 16'd0, 3);

    // Load-use: one stall, then both operands from MEM
    cyc(1'b1, lw_3,      1'b0, 1'b0, DUT_FWD, 1'b0, 2'd0, 2'd0, 16'd0, "lw_issue");
    cyc(1'b1, add_4_3_3, 1'b0, 1'b0, DUT_FWD, 1'b1, 2'd0, 2'd0, 16'd0, "load_use_stall");
    cyc(1'b1, add_4_3_3, 1'b0, 1'b0, DUT_FWD, 1'b0, 2'd2, 2'd2, 16'd1, "load_use_fwd_mem");
    nops(DUT_FWD, 16'd1, 3);

    // Producer of $0 is not tracked
    cyc(1'b1, r_ins(5'd1, 5'd2, 5'd0, 6'h20), 1'b0, 1'b0, DUT_FWD, 1'b0, 2'd0, 2'd0, 16'd1, "write_r0");
    cyc(1'b1, r_ins(5'd0, 5'd0, 5'd5, 6'h20), 1'b0, 1'b0, DUT_FWD, 1'b0, 2'd0, 2'd0, 16'd1, "read_r0");
    nops(DUT_FWD, 16'd1, 3);

    // Flush during a load-use hazard: no stall, bubble enters EX
    cyc(1'b1, lw_3,      1'b0, 1'b0, DUT_FWD, 1'b0, 2'd0, 2'd0, 16'd1, "lw_before_flush");
    cyc(1'b1, add_4_3_3, 1'b0, 1'b1, DUT_FWD, 1'b0, 2'd0, 2'd0, 16'd1, "flush_hazard");
    cyc(1'b1, or_6_4_0,  1'b0, 1'b0, DUT_FWD, 1'b0, 2'd0, 2'd0, 16'd1, "flushed_not_tracked");
    nops(DUT_FWD, 16'd1, 3);

    // External hold during a hazard: scoreboard and counter frozen
    cyc(1'b1, lw_3, 1'b0, 1'b0, DUT_FWD, 1'b0, 2'd0, 2'd0, 16'd1, "lw_before_hold");
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, add_4_3_3, 1'b1, 1'b0, DUT_FWD, 1'b1, 2'd0, 2'd0, 16'd1, "hold_frozen");
    end
    cyc(1'b1, add_4_3_3, 1'b0, 1'b0, DUT_FWD, 1'b1, 2'd0, 2'd0, 16'd1, "hold_release_stall");
    cyc(1'b1, add_4_3_3, 1'b0, 1'b0, DUT_FWD, 1'b0, 2'd2, 2'd2, 16'd2, "hold_then_fwd");
    nops(DUT_FWD, 16'd2, 3);

    // Asynchronous reset in the middle of a stall
    cyc(1'b1, lw_3,      1'b0, 1'b0, DUT_FWD, 1'b0, 2'd0, 2'd0, 16'd2, "lw_before_rst");
    cyc(1'b1, add_4_3_3, 1'b0, 1'b0, DUT_FWD, 1'b1, 2'd0, 2'd0, 16'd2, "stall_before_rst");
    cyc(1'b0, add_4_3_3, 1'b0, 1'b0, DUT_FWD, 1'b0, 2'd0, 2'd0, 16'd0, "async_rst_mid_stall");
    cyc(1'b1, 32'b0,     1'b0, 1'b0, DUT_FWD, 1'b0, 2'd0, 2'd0, 16'd0, "after_rst");

    // No forwarding: DEPTH stall cycles until the producer retires
    cyc(1'b1, add_3_1_2, 1'b0, 1'b0, DUT_NOF, 1'b0, 2'd0, 2'd0, 16'd0, "nof_add");
    cyc(1'b1, or_6_3_0,  1'b0, 1'b0, DUT_NOF, 1'b1, 2'd0, 2'd0, 16'd0, "nof_stall_1");
    cyc(1'b1, or_6_3_0,  1'b0, 1'b0, DUT_NOF, 1'b1, 2'd0, 2'd0, 16'd1, "nof_stall_2");
    cyc(1'b1, or_6_3_0,  1'b0, 1'b0, DUT_NOF, 1'b1, 2'd0, 2'd0, 16'd2, "nof_stall_3");
    cyc(1'b1, or_6_3_0,  1'b0, 1'b0, DUT_NOF, 1'b0, 2'd0, 2'd0, 16'd3, "nof_issue");

    // Saturation with a 4-bit counter
    cyc(1'b0, 32'b0, 1'b0, 1'b0, DUT_SAT, 1'b0, 2'd0, 2'd0, 16'd0, "reset_sat");
    for (int i = 0; i < 18; i++) begin
      c = (i < 15) ? 16'(i) : 16'd15;
      cyc(1'b1, lw_3,      1'b0, 1'b0, DUT_SAT, 1'b0, 2'd0, 2'd0, c, "sat_lw");
      cyc(1'b1, add_4_3_3, 1'b0, 1'b0, DUT_SAT, 1'b1, 2'd0, 2'd0, c, "sat_stall");
      c = (i + 1 < 15) ? 16'(i + 1) : 16'd15;
      cyc(1'b1, add_4_3_3, 1'b0, 1'b0, DUT_SAT, 1'b0, 2'd2, 2'd2, c, "sat_fwd");
    end

    // Reset mid-stall drops stall, except while hold_ext is high
    cyc(1'b1, lw_3,      1'b0, 1'b0, DUT_SAT, 1'b0, 2'd0, 2'd0, 16'd15, "sat_lw_final");
    cyc(1'b1, add_4_3_3, 1'b0, 1'b0, DUT_SAT, 1'b1, 2'd0, 2'd0, 16'd15, "sat_stall_final");
    cyc(1'b0, add_4_3_3, 1'b0, 1'b0, DUT_SAT, 1'b0, 2'd0, 2'd0, 16'd0,  "sat_async_rst");
    cyc(1'b0, add_4_3_3, 1'b1, 1'b0, DUT_SAT, 1'b1, 2'd0, 2'd0, 16'd0,  "rst_with_hold");
    cyc(1'b1, 32'b0,     1'b0, 1'b0, DUT_SAT, 1'b0, 2'd0, 2'd0, 16'd0,  "sat_after_rst");

    // Drain the scoreboard queue within a bounded number of cycles
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_unit.md
# pipeline_hazard_unit

Parametrised hazard-detection and forwarding-control block for the five-stage MIPS pipeline, sitting beside the ID stage. It keeps its own scoreboard of destination registers for in-flight instructions (EX through WB), compares the sources of the instruction in ID against it, and raises a stall or selects a forwarding path. It supports a no-forwarding mode, configurable tracking depth and load latency, an external hold, branch flush, and a saturating stall-cycle counter.

## Interface
- `REG_AW`, 5: register-address width.
- `DEPTH`, 3: tracked in-flight stages; entry 0 = EX, entry DEPTH-1 = WB.
- `FWD_EN`, 1: 1 = forwarding with load-use stall only; 0 = stall on any pending match.
- `LOAD_LAT`, 1: number of youngest entries where load data is not yet forwardable (1..DEPTH-1).
- `CNT_W`, 16: stall counter width.
- `clk` in 1: the single clock; all state updates on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_ir` in 32: instruction in ID; 32'b0 = bubble/NOP.
- `hold_ext` in 1: external freeze (memory wait).
- `flush` in 1: squash ID instruction (taken branch/jump).
- `stall` out 1: hold PC and IF/ID, insert bubble into EX.
- `fwd_a_sel` out $clog2(DEPTH+1): rs source; 0 = register file, k = entry k-1.
- `fwd_b_sel` out $clog2(DEPTH+1): rt source, same encoding.
- `stall_cycles` out CNT_W: hazard stall cycles since reset.

## Operation
- Decode of `id_ir[31:26]`:
  - 000000 R-type: uses rs and rt; writes rd.
  - 100011 lw: uses rs; writes rt; is_load.
  - 101011 sw: uses rs and rt; no write.
  - 000010 j: no use; no write.
  - 000100 beq, 000101 bne: use rs and rt; no write.
  - all others (I-type): use rs; write rt.
- A write to register 0 is recorded as no-write. An all-zero IR uses and writes nothing.
- Scoreboard entry: {we, dst[REG_AW-1:0], is_load}.
- Match per source: find the youngest entry k with we=1 and dst equal to the source.
  - FWD_EN=0: any match gives a hazard; fwd sel is 0.
  - FWD_EN=1: if entry k has is_load and k<LOAD_LAT, it is a hazard. Otherwise fwd sel = k+1.
  - No match: fwd sel = 0.
- `stall` = hold_ext | (hazard & ~flush).
- fwd sels are forced to 0 when there is a hazard or a flush.
- Scoreboard update each cycle:
  - hold_ext=1: no change; flush ignored (upstream keeps flush asserted).
  - otherwise: entry[i+1] <= entry[i].
  - entry[0] <= bubble (we=0) if hazard or flush, else the decoded ID instruction.
  - The oldest entry retires.
- `stall_cycles` increments when hazard & ~flush & ~hold_ext. It saturates at all-ones.

## Timing
- `stall` and fwd sels are combinational from `id_ir`/`flush`/`hold_ext` and the registered scoreboard. There is no internal combinational loop.
- Scoreboard and counter are registered.
- Reset (asynchronous, rst_n=0): all entries we=0, `stall_cycles`=0. With IR=0 and hold_ext=0: `stall`=0, fwd sels=0.
- Reset mid-stall drops `stall` immediately, unless hold_ext is high.
- Load-use with FWD_EN=1 and LOAD_LAT=1: exactly 1 stall cycle, then fwd sel=2 (MEM).
- FWD_EN=0: a producer directly ahead stalls DEPTH cycles; the instruction issues when the producer retires past WB.
- Both sources hazardous: a single stall; the counter still increments by 1.

## Structure
- `hazard_pkg`: opcode constants, scoreboard entry struct, decoded-instruction struct, fwd-select width function.
- Sub-module `hazard_decode`: combinational IR → {use_rs, use_rt, we, dst, is_load}. It is instantiated for ID.
- Top level: scoreboard shift array, match/priority logic, counter.

## Test plan
- Back-to-back `add $3,$1,$2` then `sub $4,$3,$5`, FWD_EN=1 → `stall`=0, `fwd_a_sel`=1 in the sub's ID cycle.
- `lw $3,0($1)` then `add $4,$3,$3` → `stall`=1 for one cycle, then `fwd_a_sel`=`fwd_b_sel`=2; `stall_cycles`=1.
- FWD_EN=0, DEPTH=3: `add $3,...` then `or $6,$3,$0` → `stall` high for 3 cycles, then low; counter=3.
- Producer writing $0, then a consumer of $0 → no stall, fwd sels 0.
- Load-use hazard with `flush`=1 in the same cycle → `stall`=0, bubble enters EX, counter unchanged. `hold_ext`=1 for 4 cycles during a hazard → `stall`=1, scoreboard frozen, counter unchanged.
- Force `stall_cycles` near all-ones with repeated load-use hazards (CNT_W=4) → it saturates at 15. Assert `rst_n`=0 mid-stall → `stall`=0 and counter 0 asynchronously.
